// File: rtl/temp_fan_ctrl.sv
// Temperature-band fan controller: debounced band input, soft-ramped motor PWM,
// 7-segment and RGB status, gated alarm buzzer and a sensor-loss fail-safe.
module temp_fan_ctrl #(
    parameter int unsigned LEVELS        = 3,
    parameter int unsigned PWM_PERIOD    = 100000,
    parameter int unsigned RAMP_STEP     = 10000,
    parameter int unsigned STABLE_CYCLES = 50000,
    parameter int unsigned FAULT_TIMEOUT = 50000000,
    parameter int unsigned BUZZ_PERIOD   = 100000,
    parameter int unsigned BUZZ_ON       = 10000
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [LEVELS-1:0] temp_in,
    input  logic              alarm_on_off,
    output logic              motor,
    output logic [7:0]        seg,
    output logic [3:0]        digit_en,
    output logic [2:0]        rgb,
    output logic              buzzer,
    output logic [1:0]        level,
    output logic              fault
);

    localparam int unsigned CW = $clog2(PWM_PERIOD + 1);
    localparam int unsigned SW = $clog2(STABLE_CYCLES + 1);
    localparam int unsigned FW = $clog2(FAULT_TIMEOUT + 1);
    localparam int unsigned BW = $clog2(BUZZ_PERIOD + 1);

    // Band duty, clamped so unused table entries never overflow the duty width.
    function automatic int unsigned band_duty(input int unsigned lvl);
        int unsigned d;
        d = lvl * PWM_PERIOD / (LEVELS - 1);
        return (d > PWM_PERIOD) ? PWM_PERIOD : d;
    endfunction

    localparam int unsigned RAMP_EFF = (RAMP_STEP > PWM_PERIOD) ? PWM_PERIOD : RAMP_STEP;
    localparam int unsigned BON_EFF  = (BUZZ_ON > BUZZ_PERIOD) ? BUZZ_PERIOD : BUZZ_ON;

    localparam logic [CW-1:0] PWM_LAST    = CW'(PWM_PERIOD - 1);
    localparam logic [CW-1:0] DUTY_FULL   = CW'(PWM_PERIOD);
    localparam logic [CW-1:0] RAMP        = CW'(RAMP_EFF);
    localparam logic [CW-1:0] DUTY_L1     = CW'(band_duty(1));
    localparam logic [CW-1:0] DUTY_L2     = CW'(band_duty(2));
    localparam logic [CW-1:0] DUTY_L3     = CW'(band_duty(3));
    localparam logic [SW-1:0] STABLE_LAST = SW'(STABLE_CYCLES - 1);
    localparam logic [FW-1:0] FAULT_LAST  = FW'(FAULT_TIMEOUT);
    localparam logic [BW-1:0] BUZZ_LAST   = BW'(BUZZ_PERIOD - 1);
    localparam logic [BW-1:0] BUZZ_ON_C   = BW'(BON_EFF);
    localparam logic [1:0]    TOP_LEVEL   = 2'(LEVELS - 1);

    typedef enum logic [1:0] {StWait, StRun, StFault} state_e;

    state_e        state_q, state_d;
    logic [1:0]    level_q, level_d;
    logic [2:0]    raw_code, prev_code_q;
    logic [SW-1:0] stable_cnt_q;
    logic          commit;
    logic [FW-1:0] fault_tmr_q;
    logic          fault_expired;
    logic [CW-1:0] pwm_cnt_q, duty_q, duty_d, run_target, target;
    logic          pwm_wrap;
    logic [BW-1:0] bcnt_q;
    logic          buzz_active;

    assign level = level_q;

    // Lowest set band wins; 0 means the sensor link reports nothing.
    always_comb begin
        raw_code = '0;
        for (int k = 0; k < LEVELS; k++) begin
            if (temp_in[k] && raw_code == 3'd0) raw_code = 3'(k + 1);
        end
    end

    assign commit = (stable_cnt_q == STABLE_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prev_code_q  <= '0;
            stable_cnt_q <= '0;
        end else begin
            prev_code_q <= raw_code;
            if (raw_code != prev_code_q) begin
                stable_cnt_q <= '0;
            end else if (!commit) begin
                stable_cnt_q <= stable_cnt_q + 1'b1;
            end
        end
    end

    // A held-stable code recommits every cycle; all transitions are idempotent.
    always_comb begin
        state_d = state_q;
        level_d = level_q;
        if (commit) begin
            if (prev_code_q == 3'd0) begin
                state_d = StFault;
            end else begin
                state_d = StRun;
                level_d = 2'(prev_code_q - 3'd1);
            end
        end
    end

    function automatic logic [7:0] seg_font(input logic [1:0] lvl);
        case (lvl)
            2'd0:    return 8'hF9;
            2'd1:    return 8'hA4;
            2'd2:    return 8'hB0;
            default: return 8'h99;
        endcase
    endfunction

    assign fault_expired = (fault_tmr_q == FAULT_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StWait;
            level_q     <= '0;
            fault_tmr_q <= '0;
            seg         <= 8'hFF;
            digit_en    <= 4'hF;
            rgb         <= 3'b111;
            fault       <= 1'b0;
        end else begin
            state_q <= state_d;
            level_q <= level_d;
            if (state_q == StFault && state_d == StFault) begin
                if (!fault_expired) fault_tmr_q <= fault_tmr_q + 1'b1;
            end else begin
                fault_tmr_q <= '0;
            end
            fault <= (state_d == StFault);
            if (state_d == StRun) begin
                digit_en <= ~(4'b0001 << level_d);
                seg      <= seg_font(level_d);
                if (level_d == 2'd0)           rgb <= 3'b101;
                else if (level_d == TOP_LEVEL) rgb <= 3'b011;
                else                           rgb <= 3'b001;
            end else begin
                digit_en <= 4'h0;
                seg      <= 8'hBF;
                rgb      <= 3'b110;
            end
        end
    end

    always_comb begin
        case (level_q)
            2'd0:    run_target = '0;
            2'd1:    run_target = DUTY_L1;
            2'd2:    run_target = DUTY_L2;
            default: run_target = DUTY_L3;
        endcase
    end

    // Level is frozen while in FAULT, so the band duty is the target held on entry.
    always_comb begin
        case (state_q)
            StRun:   target = run_target;
            StFault: target = fault_expired ? DUTY_FULL : run_target;
            default: target = '0;
        endcase
    end

    always_comb begin
        duty_d = duty_q;
        if (target > duty_q) begin
            duty_d = (target - duty_q > RAMP) ? duty_q + RAMP : target;
        end else if (target < duty_q) begin
            duty_d = (duty_q - target > RAMP) ? duty_q - RAMP : target;
        end
    end

    assign pwm_wrap = (pwm_cnt_q == PWM_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pwm_cnt_q <= '0;
            duty_q    <= '0;
            motor     <= 1'b0;
        end else begin
            motor     <= (pwm_cnt_q < duty_q);
            pwm_cnt_q <= pwm_wrap ? '0 : pwm_cnt_q + 1'b1;
            if (pwm_wrap) duty_q <= duty_d;
        end
    end

    assign buzz_active = (state_q == StRun) && (level_q == TOP_LEVEL) && !alarm_on_off;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bcnt_q <= '0;
            buzzer <= 1'b1;
        end else if (buzz_active) begin
            buzzer <= !(bcnt_q < BUZZ_ON_C);
            bcnt_q <= (bcnt_q == BUZZ_LAST) ? '0 : bcnt_q + 1'b1;
        end else begin
            buzzer <= 1'b1;
            bcnt_q <= '0;
        end
    end

endmodule

// File: tb/tb_temp_fan_ctrl.sv
// Bench for temp_fan_ctrl: directed scenarios plus random band/alarm/reset traffic,
// every output compared each cycle against a behavioural model.
module tb_temp_fan_ctrl;

    localparam int L  = 3;
    localparam int P  = 10;
    localparam int RS = 5;
    localparam int SC = 4;
    localparam int FT = 20;
    localparam int BP = 8;
    localparam int BO = 2;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [L-1:0] temp_in;
    logic         alarm_on_off;
    logic         motor, buzzer, fault;
    logic [7:0]   seg;
    logic [3:0]   digit_en;
    logic [2:0]   rgb;
    logic [1:0]   level;

    temp_fan_ctrl #(
        .LEVELS(L), .PWM_PERIOD(P), .RAMP_STEP(RS), .STABLE_CYCLES(SC),
        .FAULT_TIMEOUT(FT), .BUZZ_PERIOD(BP), .BUZZ_ON(BO)
    ) dut (
        .clk(clk), .rst_n(rst_n), .temp_in(temp_in), .alarm_on_off(alarm_on_off),
        .motor(motor), .seg(seg), .digit_en(digit_en), .rgb(rgb), .buzzer(buzzer),
        .level(level), .fault(fault)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Model: 0 = WAIT, 1 = RUN, 2 = FAULT
    int m_state, m_level, m_age, m_held, m_duty, m_phase, m_brun;
    int hist[$];
    int e_motor, e_buzzer, e_seg, e_den, e_rgb, e_fault;
    int font[4] = '{'hF9, 'hA4, 'hB0, 'h99};

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int raw_of(input logic [L-1:0] t);
        for (int k = 0; k < L; k++) if (t[k]) return k + 1;
        return 0;
    endfunction

    task automatic model_reset();
        m_state = 0; m_level = 0; m_age = 0; m_held = 0; m_duty = 0; m_phase = 0; m_brun = 0;
        hist = {0};
        e_motor = 0; e_buzzer = 1; e_seg = 'hFF; e_den = 'hF; e_rgb = 7; e_fault = 0;
    endtask

    task automatic model_step();
        int commit, tgt, nst;
        bit bact;
        if (!rst_n) begin
            model_reset();
            return;
        end
        // A code is accepted once the last SC samples all agree.
        commit = -1;
        if (hist.size() == SC) begin
            commit = hist[0];
            foreach (hist[i]) if (hist[i] != hist[0]) commit = -1;
        end
        case (m_state)
            0:       tgt = 0;
            1:       tgt = m_level * P / (L - 1);
            default: tgt = (m_age >= FT) ? P : m_held;
        endcase
        if (m_state != 2) m_held = tgt;
        e_motor = (m_phase < m_duty) ? 1 : 0;
        if (m_phase == P - 1) begin
            if (tgt > m_duty) m_duty += (tgt - m_duty < RS) ? tgt - m_duty : RS;
            else              m_duty -= (m_duty - tgt < RS) ? m_duty - tgt : RS;
        end
        m_phase = (m_phase + 1) % P;
        bact = (m_state == 1) && (m_level == L - 1) && (alarm_on_off == 1'b0);
        e_buzzer = bact ? (((m_brun % BP) < BO) ? 0 : 1) : 1;
        m_brun = bact ? m_brun + 1 : 0;
        nst = m_state;
        if (commit == 0) nst = 2;
        else if (commit > 0) begin
            nst = 1;
            m_level = commit - 1;
        end
        m_age = (m_state == 2 && nst == 2) ? m_age + 1 : 0;
        m_state = nst;
        e_fault = (m_state == 2) ? 1 : 0;
        if (m_state == 1) begin
            e_den = (~(1 << m_level)) & 'hF;
            e_seg = font[m_level];
            e_rgb = (m_level == 0) ? 5 : (m_level == L - 1) ? 3 : 1;
        end else begin
            e_den = 0; e_seg = 'hBF; e_rgb = 6;
        end
        hist.push_back(raw_of(temp_in));
        if (hist.size() > SC) void'(hist.pop_front());
    endtask

    initial begin
        model_reset();
        forever begin
            @(posedge clk);
            model_step();
            @(negedge clk);
            check("motor", motor, e_motor);
            check("buzzer", buzzer, e_buzzer);
            check("seg", seg, e_seg);
            check("digit_en", digit_en, e_den);
            check("rgb", rgb, e_rgb);
            check("level", level, m_level);
            check("fault", fault, e_fault);
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic count_motor(input int n, output int c);
        c = 0;
        repeat (n) begin
            @(negedge clk);
            c += int'(motor);
        end
    endtask

    task automatic count_buzz_low(input int n, output int c);
        c = 0;
        repeat (n) begin
            @(negedge clk);
            c += int'(!buzzer);
        end
    endtask

    initial begin
        int c;
        rst_n = 1'b0; temp_in = '0; alarm_on_off = 1'b1;
        tick(2);
        temp_in = 3'b001; rst_n = 1'b1;
        tick(4);
        check("still_wait_den", digit_en, 4'h0);
        tick(1);
        check("run_l0_den", digit_en, 4'hE);
        check("run_l0_seg", seg, 8'hF9);
        check("run_l0_rgb", rgb, 3'b101);
        check("run_l0_level", level, 2'd0);
        count_motor(20, c);
        check("l0_motor_off", c, 0);

        temp_in = 3'b010;
        tick(35);
        check("l1_seg", seg, 8'hA4);
        check("l1_rgb", rgb, 3'b001);
        count_motor(10, c);
        check("l1_duty_half", c, 5);

        temp_in = 3'b100; alarm_on_off = 1'b0;
        tick(35);
        check("l2_seg", seg, 8'hB0);
        check("l2_rgb", rgb, 3'b011);
        count_motor(10, c);
        check("l2_duty_full", c, 10);
        count_buzz_low(16, c);
        check("l2_buzz_lows", c, 4);
        alarm_on_off = 1'b1;
        tick(2);
        count_buzz_low(8, c);
        check("alarm_off_quiet", c, 0);

        temp_in = 3'b010;
        tick(35);
        temp_in = 3'b001;
        tick(2);
        temp_in = 3'b010;
        tick(8);
        check("glitch_level", level, 2'd1);

        temp_in = 3'b000;
        tick(5);
        check("fault_flag", fault, 1'b1);
        check("fault_seg", seg, 8'hBF);
        check("fault_den", digit_en, 4'h0);
        check("fault_rgb", rgb, 3'b110);
        count_motor(10, c);
        check("fault_hold", c, 5);
        tick(40);
        count_motor(10, c);
        check("fault_full", c, 10);
        temp_in = 3'b001;
        tick(5);
        check("recover_level", level, 2'd0);
        check("recover_fault", fault, 1'b0);
        tick(30);
        count_motor(10, c);
        check("recover_duty0", c, 0);

        temp_in = 3'b100;
        tick(43);
        #2 rst_n = 1'b0;
        #1;
        check("rst_motor", motor, 1'b0);
        check("rst_seg", seg, 8'hFF);
        check("rst_den", digit_en, 4'hF);
        check("rst_rgb", rgb, 3'b111);
        check("rst_buzzer", buzzer, 1'b1);
        check("rst_level", level, 2'd0);
        check("rst_fault", fault, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        tick(1);
        check("restart_wait_den", digit_en, 4'h0);
        check("restart_wait_seg", seg, 8'hBF);

        for (int i = 0; i < 150; i++) begin
            alarm_on_off = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 39) == 0) begin
                rst_n = 1'b0;
                tick(2);
                rst_n = 1'b1;
            end else if ($urandom_range(0, 9) == 0) begin
                temp_in = '0;
                tick($urandom_range(20, 45));
            end else begin
                temp_in = 3'($urandom_range(0, 7));
                tick($urandom_range(1, 14));
            end
        end
        tick(2);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
